pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 stall_if_i  input  1  hold PC; IF stage frozen.
REQ-005 stall_id_i  input  1  hold IF/ID register; ID stage frozen.
REQ-006 branch_flag_i  input  1  taken branch/jump resolved in ID.
REQ-007 branch_target_i  input  32  branch destination address.
REQ-008 flush_i  input  1  pipeline flush (exception/eret).
REQ-009 new_pc_i  input  32  redirect address accompanying flush_i.
REQ-010 inst_i  input  32  instruction word from instruction ROM (combinational, same cycle as pc_o).
REQ-011 pc_o  output  32  fetch address to instruction ROM.
REQ-012 ce_o  output  1  ROM chip enable (1 = enable).
REQ-013 id_pc_o  output  32  registered PC of instruction handed to decode.
REQ-014 id_inst_o  output  32  registered instruction handed to decode.

Function
REQ-015 Effective IF stall SHALL be stall_if_i | stall_id_i.
REQ-016 First rising edge after rst deasserts: ce_o SHALL go 1, pc_o SHALL stay RESET_PC; PC SHALL not advance while ce_o is 0.
REQ-017 With ce_o=1, PC next-value priority per edge: flush_i -> new_pc_i; else stall -> hold; else pending branch -> pending target; else branch_flag_i -> branch_target_i; else pc_o+4.
REQ-018 pc_o[1:0] SHALL always be 2'b00; bits [1:0] of branch_target_i and new_pc_i SHALL be ignored.
REQ-019 pc_o+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 branch_flag_i asserted during a stall SHALL be latched (target + pending bit) and applied on the first non-stalled, non-flushed edge, then the pending bit cleared; a later branch_flag_i while pending SHALL overwrite the target.
REQ-021 flush_i SHALL clear the pending bit on the same edge.
REQ-022 IF/ID register per edge, priority: flush_i -> id_pc_o=0, id_inst_o=0; else stall_id_i -> hold; else stall_if_i -> bubble (zeros); else ce_o=0 -> zeros; else load pc_o / inst_i.
REQ-023 Latency: an instruction at pc_o in cycle N SHALL appear on id_inst_o/id_pc_o in cycle N+1 absent stall/flush.
REQ-024 ce_o SHALL remain 1 until the next reset.

Reset
REQ-025 While rst=1: pc_o=RESET_PC, ce_o=0, id_pc_o=0, id_inst_o=0, pending bit=0, pending target=0.
REQ-026 Reset asserted mid-stall or mid-pending-branch SHALL discard all in-flight state immediately (asynchronous).

Configuration
REQ-027 Macro BRANCH_DELAY_SLOT_EN defined: on a branch-taking edge the instruction currently at pc_o (delay slot) SHALL load into IF/ID normally.
REQ-028 BRANCH_DELAY_SLOT_EN undefined: on a branch-taking edge (including pending-branch application) IF/ID SHALL load a bubble (zeros) instead.

Structure
REQ-029 Shared package SHALL hold: 32-bit address/instruction widths, ZeroWord, NOP encoding (32'h0), ChipEnable/ChipDisable constants, PC increment (4).
REQ-030 One sub-module if_id_reg (IF/ID pipeline register, REQ-022/027/028); PC, ce and pending-branch logic reside in pc_fetch.

Verification
REQ-031 Reset release, no stalls, ROM word = address -> pc_o 0,0,4,8,...; id_inst_o lags pc_o by one cycle; id_pc_o = id_inst_o.
REQ-032 At pc_o=0x10 assert branch_flag_i, target 0x40 -> next pc_o=0x40; id_inst_o next cycle = word@0x10 with BRANCH_DELAY_SLOT_EN, 0 without.
REQ-033 stall_if_i=1 for 3 cycles with branch_flag_i pulse (target 0x80) in cycle 1 -> pc_o held 3 cycles, then 0x80; id_inst_o zeros during stall (stall_id_i=0).
REQ-034 stall_id_i=1 for 2 cycles -> pc_o and id_inst_o/id_pc_o both held; resume continues at held pc_o+4.
REQ-035 flush_i with new_pc_i=0x0000_0183 while branch pending -> pc_o=0x180, id_* = 0, pending branch not applied.
REQ-036 Force PC to 0xFFFF_FFFC via flush, then run -> pc_o=0x0000_0000; assert rst mid-run -> outputs at REQ-025 values without a clock edge.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared widths, constants and helpers for the instruction-fetch stage.
// Used by pc_fetch, if_id_reg and the pc_fetch_if bus interface.
package pc_fetch_pkg;

  localparam int AddrWidth = 32;
  localparam int InstWidth = 32;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [InstWidth-1:0] inst_t;

  localparam addr_t ZeroWord    = 32'h0000_0000;
  localparam inst_t NopInst     = 32'h0000_0000;
  localparam logic  ChipEnable  = 1'b1;
  localparam logic  ChipDisable = 1'b0;
  localparam addr_t PcIncrement = 32'd4;

  // The fetch unit idles for exactly one edge after reset, then runs forever.
  typedef enum logic {
    FetchIdle = 1'b0,
    FetchRun  = 1'b1
  } fetch_state_e;

  // Instruction addresses are word aligned, so the two low bits are dropped.
  function automatic addr_t alignWord(input addr_t a);
    return a & ~addr_t'(3);
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Bus between the fetch stage and its surroundings (control, ROM, decode).
// The fetch stage uses the slave modport; the pipeline/testbench uses master.
interface pc_fetch_if;
  import pc_fetch_pkg::*;

  logic  stall_if_i;
  logic  stall_id_i;
  logic  branch_flag_i;
  addr_t branch_target_i;
  logic  flush_i;
  addr_t new_pc_i;
  inst_t inst_i;
  addr_t pc_o;
  logic  ce_o;
  addr_t id_pc_o;
  inst_t id_inst_o;

  modport master (
    output stall_if_i, stall_id_i, branch_flag_i, branch_target_i,
           flush_i, new_pc_i, inst_i,
    input  pc_o, ce_o, id_pc_o, id_inst_o
  );

  modport slave (
    input  stall_if_i, stall_id_i, branch_flag_i, branch_target_i,
           flush_i, new_pc_i, inst_i,
    output pc_o, ce_o, id_pc_o, id_inst_o
  );

endinterface

// File: rtl/pc_fetch_if_id_reg.sv
// IF/ID pipeline register: flush, hold, bubble or load of the fetched word.
// Macro BRANCH_DELAY_SLOT_EN keeps the delay-slot instruction on a taken branch.
module if_id_reg
  import pc_fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_flush,
  input  logic  i_stallId,
  input  logic  i_stallIf,
  input  logic  i_ce,
  input  logic  i_branchTaken,
  input  addr_t i_pc,
  input  inst_t i_inst,
  output addr_t o_idPc,
  output inst_t o_idInst
);

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit SquashOnBranch = 1'b0;
`else
  localparam bit SquashOnBranch = 1'b1;
`endif

  logic  w_squash;
  addr_t r_idPc;
  inst_t r_idInst;

  assign w_squash = SquashOnBranch & i_branchTaken;

  // Flush beats a decode hold; a fetch-only stall or idle fetch inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idPc   <= ZeroWord;
      r_idInst <= NopInst;
    end else if (i_flush) begin
      r_idPc   <= ZeroWord;
      r_idInst <= NopInst;
    end else if (i_stallId) begin
      r_idPc   <= r_idPc;
      r_idInst <= r_idInst;
    end else if (i_stallIf || (i_ce != ChipEnable) || w_squash) begin
      r_idPc   <= ZeroWord;
      r_idInst <= NopInst;
    end else begin
      r_idPc   <= i_pc;
      r_idInst <= i_inst;
    end
  end

  assign o_idPc   = r_idPc;
  assign o_idInst = r_idInst;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: program counter, ROM enable and deferred branches.
// BRANCH_DELAY_SLOT_EN selects delay-slot behaviour inside if_id_reg.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter addr_t RESET_PC = 32'h0000_0000
) (
  input logic     clk,
  input logic     rst,
  pc_fetch_if.slave bus
);

  fetch_state_e r_state;
  fetch_state_e w_nextState;
  addr_t        r_pc;
  addr_t        w_nextPc;
  logic         r_pendValid;
  addr_t        r_pendTarget;
  logic         w_run;
  logic         w_stall;
  logic         w_takeBranch;

  assign w_run   = (r_state == FetchRun);
  assign w_stall = bus.stall_if_i | bus.stall_id_i;

  // A branch takes effect only on an edge that is running, unstalled and unflushed.
  assign w_takeBranch = w_run & ~bus.flush_i & ~w_stall &
                        (r_pendValid | bus.branch_flag_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FetchIdle;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FetchIdle: w_nextState = FetchRun;
      FetchRun:  w_nextState = FetchRun;
      default:   w_nextState = FetchIdle;
    endcase
  end

  always_comb begin
    w_nextPc = r_pc;
    if (w_run) begin
      if (bus.flush_i) begin
        w_nextPc = alignWord(bus.new_pc_i);
      end else if (w_stall) begin
        w_nextPc = r_pc;
      end else if (r_pendValid) begin
        w_nextPc = r_pendTarget;
      end else if (bus.branch_flag_i) begin
        w_nextPc = alignWord(bus.branch_target_i);
      end else begin
        w_nextPc = r_pc + PcIncrement;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= alignWord(RESET_PC);
    end else begin
      r_pc <= w_nextPc;
    end
  end

  // Branches resolved while stalled are parked here; a newer one overwrites the target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pendValid  <= 1'b0;
      r_pendTarget <= ZeroWord;
    end else if (w_run) begin
      if (bus.flush_i) begin
        r_pendValid <= 1'b0;
      end else if (w_stall) begin
        if (bus.branch_flag_i) begin
          r_pendValid  <= 1'b1;
          r_pendTarget <= alignWord(bus.branch_target_i);
        end
      end else if (r_pendValid) begin
        r_pendValid <= 1'b0;
      end
    end
  end

  if_id_reg u_ifIdReg (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (bus.flush_i),
    .i_stallId     (bus.stall_id_i),
    .i_stallIf     (bus.stall_if_i),
    .i_ce          (w_run ? ChipEnable : ChipDisable),
    .i_branchTaken (w_takeBranch),
    .i_pc          (r_pc),
    .i_inst        (bus.inst_i),
    .o_idPc        (bus.id_pc_o),
    .o_idInst      (bus.id_inst_o)
  );

  assign bus.pc_o = r_pc;
  assign bus.ce_o = w_run ? ChipEnable : ChipDisable;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the fetch stage.
module tb_pc_fetch;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DelaySlot = 1'b1;
`else
  localparam bit DelaySlot = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] romKey = 32'h0;
  int          assertCount = 0;
  int          failCount = 0;

  pc_fetch_if bus ();

  pc_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ROM is combinational on pc_o; romKey scrambles words so pc and inst differ.
  assign bus.inst_i = bus.pc_o ^ romKey;

  // Behavioural model state
  logic [31:0] mPc = 32'h0;
  logic        mCe = 1'b0;
  logic        mPend = 1'b0;
  logic [31:0] mPendT = 32'h0;
  logic [31:0] mIdPc = 32'h0;
  logic [31:0] mIdInst = 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPc = 32'h0; mCe = 1'b0; mPend = 1'b0; mPendT = 32'h0;
      mIdPc = 32'h0; mIdInst = 32'h0;
    end else begin
      logic stall, taking;
      stall  = bus.stall_if_i | bus.stall_id_i;
      taking = mCe && !bus.flush_i && !stall && (mPend || bus.branch_flag_i);
      if (bus.flush_i) begin
        mIdPc = 0; mIdInst = 0;
      end else if (bus.stall_id_i) begin
        mIdPc = mIdPc;
      end else if (bus.stall_if_i || !mCe || (taking && !DelaySlot)) begin
        mIdPc = 0; mIdInst = 0;
      end else begin
        mIdPc = mPc; mIdInst = mPc ^ romKey;
      end
      if (mCe) begin
        if (bus.flush_i) begin
          mPc = {bus.new_pc_i[31:2], 2'b00};
          mPend = 1'b0;
        end else if (stall) begin
          if (bus.branch_flag_i) begin
            mPend = 1'b1;
            mPendT = {bus.branch_target_i[31:2], 2'b00};
          end
        end else if (mPend) begin
          mPc = mPendT;
          mPend = 1'b0;
        end else if (bus.branch_flag_i) begin
          mPc = {bus.branch_target_i[31:2], 2'b00};
        end else begin
          mPc = mPc + 32'd4;
        end
      end
      mCe = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model pc_o", bus.pc_o, mPc);
    checkOutput("model ce_o", {31'b0, bus.ce_o}, {31'b0, mCe});
    checkOutput("model id_pc_o", bus.id_pc_o, mIdPc);
    checkOutput("model id_inst_o", bus.id_inst_o, mIdInst);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic sif, input logic sid, input logic bf,
                               input logic [31:0] bt, input logic fl,
                               input logic [31:0] np);
    bus.stall_if_i = sif;
    bus.stall_id_i = sid;
    bus.branch_flag_i = bf;
    bus.branch_target_i = bt;
    bus.flush_i = fl;
    bus.new_pc_i = np;
    tick();
  endtask

  task automatic checkAll(input string tag, input logic [31:0] pc, input logic ce,
                          input logic [31:0] idPc, input logic [31:0] idInst);
    checkOutput({tag, " pc_o"}, bus.pc_o, pc);
    checkOutput({tag, " ce_o"}, {31'b0, bus.ce_o}, {31'b0, ce});
    checkOutput({tag, " id_pc_o"}, bus.id_pc_o, idPc);
    checkOutput({tag, " id_inst_o"}, bus.id_inst_o, idInst);
  endtask

  initial begin
    logic [31:0] ds10, ds40;
    ds10 = DelaySlot ? 32'h10 : 32'h0;
    ds40 = DelaySlot ? 32'h40 : 32'h0;
    bus.stall_if_i = 0; bus.stall_id_i = 0; bus.branch_flag_i = 0;
    bus.branch_target_i = 0; bus.flush_i = 0; bus.new_pc_i = 0;

    #3;
    checkAll("reset", 32'h0, 1'b0, 32'h0, 32'h0);
    #4 rst = 1'b0;

    // Reset release and sequential fetch, ROM word = address
    applyStimulus(0, 0, 0, 0, 0, 0); checkAll("rel1", 32'h0, 1'b1, 32'h0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0); checkAll("rel2", 32'h4, 1'b1, 32'h0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0); checkAll("rel3", 32'h8, 1'b1, 32'h4, 32'h4);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0); checkAll("rel5", 32'h10, 1'b1, 32'hC, 32'hC);

    // Direct branch from 0x10 to 0x40
    applyStimulus(0, 0, 1, 32'h40, 0, 0); checkAll("branch", 32'h40, 1'b1, ds10, ds10);

    // Branch latched during a three-cycle IF stall
    applyStimulus(1, 0, 1, 32'h80, 0, 0); checkAll("stallIf1", 32'h40, 1'b1, 32'h0, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0); checkAll("stallIf3", 32'h40, 1'b1, 32'h0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0); checkAll("pendApply", 32'h80, 1'b1, ds40, ds40);
    applyStimulus(0, 0, 0, 0, 0, 0); checkAll("after pend", 32'h84, 1'b1, 32'h80, 32'h80);

    // Decode stall holds both PC and IF/ID
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0); checkAll("stallId", 32'h84, 1'b1, 32'h80, 32'h80);
    applyStimulus(0, 0, 0, 0, 0, 0); checkAll("resume", 32'h88, 1'b1, 32'h84, 32'h84);

    // Flush cancels a pending branch and drops the low address bits
    applyStimulus(1, 0, 1, 32'h200, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h183); checkAll("flush", 32'h180, 1'b1, 32'h0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0); checkAll("postFlush", 32'h184, 1'b1, 32'h180, 32'h180);

    // Wrap at the top of the address space
    applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFF); checkAll("top", 32'hFFFF_FFFC, 1'b1, 32'h0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0); checkAll("wrap", 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);

    // Asynchronous reset with a branch pending
    applyStimulus(1, 0, 1, 32'h300, 0, 0);
    bus.stall_if_i = 0; bus.branch_flag_i = 0;
    #1 rst = 1'b1;
    #1 checkAll("asyncRst", 32'h0, 1'b0, 32'h0, 32'h0);
    #1 rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0); checkAll("rstDiscard", 32'h4, 1'b1, 32'h0, 32'h0);

    // Randomized traffic checked by the model every cycle
    romKey = $urandom;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #1 rst = 1'b0;
      end
      applyStimulus($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                    $urandom_range(0, 99) < 20, $urandom,
                    $urandom_range(0, 99) < 5, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
